// File: rtl/alu_seq.sv
// Sequential EX-stage ALU: single-cycle ops, iterative RV-M multiply, and an
// iterative divide/remainder that is only built when DIV_EN is defined.
// Ports: clk, rst (sync, active-high); in_valid/in_ready, op1, op2, alu_sel
// on the request side; out_valid/out_ready, alu_out on the result side.
module alu_seq #(
    parameter int XLEN      = 32,
    parameter int LUI_SHIFT = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [4:0]      alu_sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_out
);
    localparam int SHAMT_W = $clog2(XLEN);
    localparam logic [SHAMT_W-1:0] LAST = SHAMT_W'(XLEN - 1);

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLL    = 5'd2;
    localparam logic [4:0] OP_SLT    = 5'd3;
    localparam logic [4:0] OP_SLTU   = 5'd4;
    localparam logic [4:0] OP_XOR    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_OR     = 5'd8;
    localparam logic [4:0] OP_AND    = 5'd9;
    localparam logic [4:0] OP_LUI    = 5'd10;
    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_MULHU  = 5'd19;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_REM    = 5'd22;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state;
    logic [SHAMT_W-1:0]  count;
    // mul: {partial hi, multiplier shifting out}; div: {remainder, quotient}
    logic [2*XLEN-1:0]   acc;
    logic [XLEN-1:0]     opb;
    logic                neg_a;
    logic                lo_half;

    logic                accept;
    logic [SHAMT_W-1:0]  shamt;
    logic                s1, s2, is_mul, start_iter;
    logic [XLEN-1:0]     abs1, abs2, short_res;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next, mul_prod, iter_next;
    logic [XLEN-1:0]     mul_res, final_res;

    assign in_ready = !rst && (state == IDLE || (state == DONE && out_ready));
    assign accept   = in_valid && in_ready;
    assign shamt    = op2[SHAMT_W-1:0];

    assign is_mul = alu_sel inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    assign s1 = alu_sel inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    assign s2 = alu_sel inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    assign abs1 = (s1 && op1[XLEN-1]) ? -op1 : op1;
    assign abs2 = (s2 && op2[XLEN-1]) ? -op2 : op2;

`ifdef DIV_EN
    logic                neg_b, is_div_r, is_rem;
    logic                is_div, div_short, ovf;
    logic [XLEN:0]       rs;
    logic                ge;
    logic [XLEN-1:0]     sub;
    logic [2*XLEN-1:0]   div_next;
    logic [XLEN-1:0]     q, r, div_res;

    assign is_div    = alu_sel inside {[5'd20:5'd23]};
    assign ovf       = s2 && op1 == {1'b1, {(XLEN-1){1'b0}}} && &op2;
    assign div_short = op2 == '0 || ovf;
    assign start_iter = is_mul || (is_div && !div_short);

    // Restoring step: shift one dividend bit into the remainder, subtract
    // the divisor if it fits. rs < 2*opb, so the XLEN-bit difference is exact.
    assign rs  = acc[2*XLEN-1:XLEN-1];
    assign ge  = rs >= {1'b0, opb};
    assign sub = rs[XLEN-1:0] - opb;
    assign div_next = ge ? {sub, acc[XLEN-2:0], 1'b1}
                         : {rs[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    assign q = div_next[XLEN-1:0];
    assign r = div_next[2*XLEN-1:XLEN];
    assign div_res = is_rem ? (neg_b ? -r : r) : (neg_a ? -q : q);
    assign iter_next = is_div_r ? div_next : mul_next;
    assign final_res = is_div_r ? div_res : mul_res;
`else
    assign start_iter = is_mul;
    assign iter_next  = mul_next;
    assign final_res  = mul_res;
`endif

    // Shift-add step; the carry lands in the top bit of the shifted acc.
    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    assign mul_next = {mul_sum, acc[XLEN-1:1]};
    assign mul_prod = neg_a ? -mul_next : mul_next;
    assign mul_res  = lo_half ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

    always_comb begin
        short_res = '0;
        case (alu_sel)
            OP_ADD:  short_res = op1 + op2;
            OP_SUB:  short_res = op1 - op2;
            OP_SLL:  short_res = op1 << shamt;
            OP_SLT:  short_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
            OP_SLTU: short_res = {{(XLEN-1){1'b0}}, op1 < op2};
            OP_XOR:  short_res = op1 ^ op2;
            OP_SRL:  short_res = op1 >> shamt;
            OP_SRA:  short_res = $signed(op1) >>> shamt;
            OP_OR:   short_res = op1 | op2;
            OP_AND:  short_res = op1 & op2;
            OP_LUI:  short_res = op1 << LUI_SHIFT;
            default: short_res = '0;
        endcase
`ifdef DIV_EN
        // alu_sel[1] selects REM/REMU within the divide group
        if (is_div) begin
            if (op2 == '0)
                short_res = alu_sel[1] ? op1 : '1;
            else if (ovf)
                short_res = alu_sel[1] ? '0 : op1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            alu_out   <= '0;
            count     <= '0;
            acc       <= '0;
            opb       <= '0;
            neg_a     <= 1'b0;
            lo_half   <= 1'b0;
`ifdef DIV_EN
            neg_b     <= 1'b0;
            is_div_r  <= 1'b0;
            is_rem    <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        if (start_iter) begin
                            state     <= BUSY;
                            out_valid <= 1'b0;
                            count     <= '0;
                            acc       <= {{XLEN{1'b0}}, abs1};
                            opb       <= abs2;
                            neg_a     <= (s1 && op1[XLEN-1]) ^ (s2 && op2[XLEN-1]);
                            lo_half   <= alu_sel == OP_MUL;
`ifdef DIV_EN
                            neg_b     <= s1 && op1[XLEN-1];
                            is_div_r  <= is_div;
                            is_rem    <= alu_sel[1];
`endif
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            alu_out   <= short_res;
                        end
                    end else if (state == DONE && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                BUSY: begin
                    acc   <= iter_next;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        count     <= '0;
                        alu_out   <= final_res;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the combinational execute ALU; sits in the EX stage between operand muxing and writeback.
- Adds a SUB opcode, masked shift amounts, a configurable XLEN, and iterative RV-M multiply.
- Optional iterative divide/remainder behind `DIV_EN`.
- Holds one operation in flight; uses valid/ready handshake on both sides so the pipeline can stall on multi-cycle ops.

Parameters:
- XLEN, 32: operand/result width; must be >= 8 and a power of two.
- LUI_SHIFT, 12: left-shift applied to op1 by the LUI opcode.
- SHAMT_W (localparam), $clog2(XLEN): shift-amount width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request this cycle.
- op1  in  XLEN  operand 1.
- op2  in  XLEN  operand 2.
- alu_sel  in  5  opcode.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- alu_out  out  XLEN  result.

Behaviour:
- Reset:
  - state=IDLE, out_valid=0, alu_out=0, iteration counter=0.
  - in_ready=0 while rst is high.
  - Reset mid-operation aborts the operation; no result is produced.
- Opcodes:
  - 0 ADD; 1 SUB; 2 SLL; 3 SLT; 4 SLTU; 5 XOR; 6 SRL; 7 SRA; 8 OR; 9 AND; 10 LUI (op1<<LUI_SHIFT); 11 NONE (0).
  - 16 MUL; 17 MULH; 18 MULHSU; 19 MULHU.
  - 20 DIV; 21 DIVU; 22 REM; 23 REMU.
  - Any other value behaves as NONE.
- Arithmetic rules:
  - Shifts use op2[SHAMT_W-1:0] only.
  - SLT/SLTU return 1 or 0, zero-extended.
  - ADD/SUB wrap modulo 2^XLEN.
- Handshake:
  - Transfer occurs when valid&ready on the same edge.
  - in_ready = (state==IDLE) | (state==DONE & out_ready), so back-to-back acceptance is allowed.
  - Operands are captured on acceptance; input changes afterwards are ignored.
- States:
  - IDLE: on accept of a single-cycle op (or a div short-case), write alu_out and go to DONE. On accept of a mul/div op, load the datapath and go to BUSY.
  - BUSY: one iteration per cycle; the counter counts 0..XLEN-1. At count XLEN-1, write alu_out and go to DONE.
  - DONE: out_valid=1. alu_out and out_valid are held stable while out_ready=0. On out_ready: go to IDLE, or re-enter IDLE/BUSY behaviour directly if a new request is accepted in the same cycle.
- Latency (accept at edge N):
  - Single-cycle ops: out_valid asserted after edge N+1... i.e. visible in cycle N+1.
  - MUL family and full divides: out_valid in cycle N+1+XLEN.
- Multiply:
  - Shift-add on |operands| with a 2*XLEN accumulator; sign fix-up by negation at the end.
  - MUL returns the low half; MULH/MULHSU/MULHU return the high half with RV-M signedness.
- Simultaneous events: out_ready and in_valid in the same DONE cycle cause a result handoff and a new accept on one edge, with no bubble.

Optional Feature:
- Macro: `DIV_EN`.
- When defined:
  - Restoring radix-2 divider sharing the BUSY counter.
  - Divide-by-zero: DIV/DIVU give all-ones; REM/REMU give op1; latency 1.
  - Signed overflow (op1=most-negative, op2=-1): DIV gives op1, REM gives 0; latency 1.
  - Remainder takes the sign of the dividend.
- When undefined: opcodes 20-23 behave as NONE (result 0, latency 1), and no divider logic is synthesised.

Test Plan:
- Reset mid-MUL (rst at BUSY cycle 5) -> next cycle: state IDLE, out_valid=0, alu_out=0, in_ready=1 once rst is low.
- SRA: op1=0x80000000, op2=0x00000024 (shamt 4), with out_ready=1 -> cycle N+1: out_valid=1, alu_out=0xF8000000.
- SUB then SLTU back-to-back with out_ready tied high:
  - SUB 5-7 -> 0xFFFFFFFE.
  - SLTU 1<2 -> 1.
  - Expect two consecutive out_valid cycles, with no bubble.
- MULH: op1=0xFFFFFFFF, op2=0x00000002 -> 0xFFFFFFFF at cycle N+33.
- Same MULH with out_ready=0 for 4 cycles -> alu_out held and in_ready=0 throughout.
- DIV_EN cases:
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at N+1.
  - REMU 7 / 0 -> 7 at N+1.
  - DIV -7 / 2 -> 0xFFFFFFFD at N+33.
  - REM -7 / 2 -> 0xFFFFFFFF at N+33.
- Without DIV_EN: DIV 10/2 -> 0 at N+1.
- XLEN=16 build: MULHU 0xFFFF*0xFFFF -> 0xFFFE at N+17.
- XLEN=16 build: SLL by op2=0x0011 -> shift by 1.
